mul_div_unit: RTL

Iterative RV32M multiply/divide unit directly downstream of the register file. It consumes the two read ports (rs1 → `a`, rs2 → `b`) and runs all eight M-extension operations with a radix-2 shift/add (multiply) or restoring shift/subtract (divide) datapath. It returns one N-bit result to the writeback mux. While `busy` is high, the core stalls the PC and holds the register-file write enable low.

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift/add multiply and restoring divide.
// Each op occupies N calc cycles plus one done cycle; sign fix-up happens on the final iteration.
module mul_div_unit #(
    parameter int unsigned N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [2:0]   i_funct3,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);
    localparam logic [N-1:0] OneN = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] One2N = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [2:0]      r_funct3;
    logic [CntW-1:0] r_cnt;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend -> quotient}.
    logic [2*N-1:0]  r_acc;
    logic [N-1:0]    r_op;
    logic [N-1:0]    r_a_raw;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_div_zero;
    logic            r_div_ovf;
    logic [N-1:0]    r_result;

    // Operand decode on the accepting edge
    logic         w_is_div_in;
    logic         w_a_signed_in;
    logic         w_b_signed_in;
    logic         w_neg_a_in;
    logic         w_neg_b_in;
    logic [N-1:0] w_abs_a;
    logic [N-1:0] w_abs_b;
    logic         w_div_zero_in;
    logic         w_div_ovf_in;

    always_comb begin
        w_is_div_in   = i_funct3[2];
        w_a_signed_in = (i_funct3 == F3Mulh) || (i_funct3 == F3Mulhsu) ||
                        (i_funct3 == F3Div)  || (i_funct3 == F3Rem);
        w_b_signed_in = (i_funct3 == F3Mulh) || (i_funct3 == F3Div) || (i_funct3 == F3Rem);
        w_neg_a_in    = w_a_signed_in & i_a[N-1];
        w_neg_b_in    = w_b_signed_in & i_b[N-1];
        w_abs_a       = w_neg_a_in ? (~i_a + OneN) : i_a;
        w_abs_b       = w_neg_b_in ? (~i_b + OneN) : i_b;
        w_div_zero_in = w_is_div_in && (i_b == '0);
        w_div_ovf_in  = ((i_funct3 == F3Div) || (i_funct3 == F3Rem)) &&
                        (i_a == MinNeg) && (i_b == '1);
    end

    // One iteration of the datapath
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_div_shift;
    logic           w_div_ge;
    logic [N-1:0]   w_div_diff;
    logic [N-1:0]   w_div_rem;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_acc_next;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_op} : {(N+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[N-1:1]};
        w_div_shift = {r_acc[2*N-1:N], r_acc[N-1]};
        w_div_ge    = w_div_shift >= {1'b0, r_op};
        // When w_div_ge holds the difference is below the divisor, so N bits suffice.
        w_div_diff  = w_div_shift[N-1:0] - r_op;
        w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[N-1:0];
        w_div_next  = {w_div_rem, r_acc[N-2:0], w_div_ge};
        w_acc_next  = r_funct3[2] ? w_div_next : w_mul_next;
    end

    // Sign correction and result selection from the final iteration's value
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_result_fin;

    always_comb begin
        w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_acc_next + One2N) : w_acc_next;
        w_quo_fix  = (r_neg_a ^ r_neg_b) ? (~w_acc_next[N-1:0] + OneN) : w_acc_next[N-1:0];
        w_rem_fix  = r_neg_a ? (~w_acc_next[2*N-1:N] + OneN) : w_acc_next[2*N-1:N];
        w_result_fin = '0;
        unique case (r_funct3)
            F3Mul:    w_result_fin = w_prod_fix[N-1:0];
            F3Mulh,
            F3Mulhsu,
            F3Mulhu:  w_result_fin = w_prod_fix[2*N-1:N];
            F3Div,
            F3Divu: begin
                if (r_div_zero) begin
                    w_result_fin = '1;
                end else if (r_div_ovf) begin
                    w_result_fin = MinNeg;
                end else begin
                    w_result_fin = w_quo_fix;
                end
            end
            F3Rem,
            F3Remu: begin
                if (r_div_zero) begin
                    w_result_fin = r_a_raw;
                end else if (r_div_ovf) begin
                    w_result_fin = '0;
                end else begin
                    w_result_fin = w_rem_fix;
                end
            end
            default: w_result_fin = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StCalc;
                end
            end
            StCalc: begin
                if (r_cnt == LastCnt) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_funct3   <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_op       <= '0;
            r_a_raw    <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && i_start) begin
                r_funct3   <= i_funct3;
                r_cnt      <= '0;
                r_op       <= w_is_div_in ? w_abs_b : w_abs_a;
                r_acc      <= {{N{1'b0}}, (w_is_div_in ? w_abs_a : w_abs_b)};
                r_a_raw    <= i_a;
                r_neg_a    <= w_neg_a_in;
                r_neg_b    <= w_neg_b_in;
                r_div_zero <= w_div_zero_in;
                r_div_ovf  <= w_div_ovf_in;
            end else if (r_state == StCalc) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    r_result <= w_result_fin;
                end
            end
        end
    end

    assign o_busy   = (r_state != StIdle);
    assign o_done   = (r_state == StDone);
    assign o_result = r_result;

endmodule
